lab2_proc_inst_encoder: RTL and testbench

LAB2_PROC_INST_ENCODER -- requirements
Module: lab2_proc_inst_encoder

---
 rtl/lab2_proc_pkg.sv | 43 ++++
 rtl/lab2_proc_imm_range_check.sv | 34 +++
 rtl/lab2_proc_inst_encoder.sv | 118 +++++++++++
 tb/tb_lab2_proc_inst_encoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_proc_pkg.sv
// Shared definitions for the lab2 instruction encoder: immediate-type codes,
// the request record, and an immediate decoder that inverts the field packing.
`timescale 1ns/1ps
package lab2_proc_pkg;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;
   localparam logic [2:0] IMM_R = 3'd5;

   // Significant immediate widths, including the implied zero LSB for B and J
   localparam int IMM_I_W  = 12;
   localparam int IMM_B_W  = 13;
   localparam int IMM_J_W  = 21;
   localparam int IMM_U_LO = 12;

   typedef struct packed {
      logic [2:0]  imm_type;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } enc_req_t;

   function automatic logic [31:0] imm_decode(input logic [2:0] imm_type, input logic [31:0] inst);
      logic [31:0] imm;
      case (imm_type)
         IMM_I:   imm = {{(32-IMM_I_W){inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{(32-IMM_I_W){inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{(32-IMM_B_W){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {inst[31:12], {IMM_U_LO{1'b0}}};
         IMM_J:   imm = {{(32-IMM_J_W){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/lab2_proc_imm_range_check.sv
// Flags immediates that cannot be represented in the selected instruction format,
// and flags the two unused type codes.
`timescale 1ns/1ps
module lab2_proc_imm_range_check
   import lab2_proc_pkg::*;
(
   input  logic [2:0]  imm_type,
   input  logic [31:0] imm,
   output logic        err
);

   logic fits_is_s;
   logic fits_b_s;
   logic fits_j_s;

   // Upper bits must be a pure sign extension of the encodable field
   assign fits_is_s = (&imm[31:11]) | ~(|imm[31:11]);
   assign fits_b_s  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
   assign fits_j_s  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

   // Select the rule that applies to this format
   always_comb begin
      err = 1'b1;
      case (imm_type)
         IMM_I, IMM_S: err = ~fits_is_s;
         IMM_B:        err = ~fits_b_s;
         IMM_U:        err = |imm[11:0];
         IMM_J:        err = ~fits_j_s;
         IMM_R:        err = 1'b0;
         default:      err = 1'b1;
      endcase
   end

endmodule

// File: rtl/lab2_proc_inst_encoder.sv
// Two-stage (X, W) valid/ready pipeline that packs instruction fields into a
// 32-bit word, flags unencodable immediates and keeps saturating statistics.
`timescale 1ns/1ps
module lab2_proc_inst_encoder
   import lab2_proc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [2:0]       req_imm_type,
   input  logic [6:0]       req_opcode,
   input  logic [2:0]       req_funct3,
   input  logic [6:0]       req_funct7,
   input  logic [4:0]       req_rd,
   input  logic [4:0]       req_rs1,
   input  logic [4:0]       req_rs2,
   input  logic [31:0]      req_imm,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic [31:0]      resp_inst,
   output logic             resp_err,
   output logic [CNT_W-1:0] num_enc,
   output logic [CNT_W-1:0] num_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   enc_req_t    req_s;
   enc_req_t    x_req_r;
   logic        x_val_r;
   logic        w_val_r;
   logic        w_adv_s;
   logic        x_adv_s;
   logic [31:0] inst_s;
   logic        err_s;
   logic        xfer_s;

   assign req_s = '{imm_type: req_imm_type, opcode: req_opcode, funct3: req_funct3,
                    funct7: req_funct7, rd: req_rd, rs1: req_rs1, rs2: req_rs2, imm: req_imm};

   assign w_adv_s  = ~w_val_r | resp_rdy;
   assign x_adv_s  = ~x_val_r | w_adv_s;
   assign req_rdy  = x_adv_s;
   assign resp_val = w_val_r;
   assign xfer_s   = w_val_r & resp_rdy;

   lab2_proc_imm_range_check u_range (
      .imm_type (x_req_r.imm_type),
      .imm      (x_req_r.imm),
      .err      (err_s)
   );

   // Field packing for each format; unused type codes encode to zero
   always_comb begin
      inst_s = 32'd0;
      case (x_req_r.imm_type)
         IMM_I:   inst_s = {x_req_r.imm[11:0], x_req_r.rs1, x_req_r.funct3, x_req_r.rd, x_req_r.opcode};
         IMM_S:   inst_s = {x_req_r.imm[11:5], x_req_r.rs2, x_req_r.rs1, x_req_r.funct3,
                            x_req_r.imm[4:0], x_req_r.opcode};
         IMM_B:   inst_s = {x_req_r.imm[12], x_req_r.imm[10:5], x_req_r.rs2, x_req_r.rs1, x_req_r.funct3,
                            x_req_r.imm[4:1], x_req_r.imm[11], x_req_r.opcode};
         IMM_U:   inst_s = {x_req_r.imm[31:12], x_req_r.rd, x_req_r.opcode};
         IMM_J:   inst_s = {x_req_r.imm[20], x_req_r.imm[10:1], x_req_r.imm[11], x_req_r.imm[19:12],
                            x_req_r.rd, x_req_r.opcode};
         IMM_R:   inst_s = {x_req_r.funct7, x_req_r.rs2, x_req_r.rs1, x_req_r.funct3, x_req_r.rd,
                            x_req_r.opcode};
         default: inst_s = 32'd0;
      endcase
   end

   // Stage X: capture the accepted request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_val_r <= 1'b0;
         x_req_r <= {($bits(enc_req_t)){1'b0}};
      end else if (x_adv_s) begin
         x_val_r <= req_val;
         if (req_val) begin
            x_req_r <= req_s;
         end
      end
   end

   // Stage W: hold the encoded word until the consumer takes it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_val_r   <= 1'b0;
         resp_inst <= 32'd0;
         resp_err  <= 1'b0;
      end else if (w_adv_s) begin
         w_val_r <= x_val_r;
         if (x_val_r) begin
            resp_inst <= inst_s;
            resp_err  <= err_s;
         end
      end
   end

   // Saturating statistics, updated only on a delivered response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         num_enc <= {CNT_W{1'b0}};
         num_err <= {CNT_W{1'b0}};
      end else if (xfer_s) begin
         if (num_enc != CNT_MAX) begin
            num_enc <= num_enc + CNT_ONE;
         end
         if (resp_err && (num_err != CNT_MAX)) begin
            num_err <= num_err + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_lab2_proc_inst_encoder.sv
// Directed and round-trip bench for lab2_proc_inst_encoder with a response
// scoreboard and a saturating counter model.
`timescale 1ns/1ps
module tb_lab2_proc_inst_encoder;
   import lab2_proc_pkg::*;

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

   logic             clk;
   logic             reset;
   logic             req_val;
   logic             req_rdy;
   logic [2:0]       req_imm_type;
   logic [6:0]       req_opcode;
   logic [2:0]       req_funct3;
   logic [6:0]       req_funct7;
   logic [4:0]       req_rd;
   logic [4:0]       req_rs1;
   logic [4:0]       req_rs2;
   logic [31:0]      req_imm;
   logic             resp_val;
   logic             resp_rdy;
   logic [31:0]      resp_inst;
   logic             resp_err;
   logic [CNT_W-1:0] num_enc;
   logic [CNT_W-1:0] num_err;

   typedef struct {
      logic [31:0] inst;
      logic        err;
      logic        rt;
      logic [2:0]  typ;
      logic [31:0] imm;
   } exp_t;

   exp_t             exp_q[$];
   exp_t             mon_e;
   logic [CNT_W-1:0] exp_enc;
   logic [CNT_W-1:0] exp_err;
   int               errors = 0;
   int               checks = 0;

   lab2_proc_inst_encoder #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_val      (req_val),
      .req_rdy      (req_rdy),
      .req_imm_type (req_imm_type),
      .req_opcode   (req_opcode),
      .req_funct3   (req_funct3),
      .req_funct7   (req_funct7),
      .req_rd       (req_rd),
      .req_rs1      (req_rs1),
      .req_rs2      (req_rs2),
      .req_imm      (req_imm),
      .resp_val     (resp_val),
      .resp_rdy     (resp_rdy),
      .resp_inst    (resp_inst),
      .resp_err     (resp_err),
      .num_enc      (num_enc),
      .num_err      (num_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request, wait for it to be accepted, record what must come back
   task automatic push(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [31:0] ei, input logic ee, input logic rt);
      req_imm_type = t;  req_opcode = op; req_funct3 = f3; req_funct7 = f7;
      req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
      req_val = 1'b1;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (req_rdy) begin
            @(posedge clk);
            #1;
            exp_q.push_back('{inst: ei, err: ee, rt: rt, typ: t, imm: imm});
            req_val = 1'b0;
            return;
         end
      end
      check("push_timeout", 32'(req_rdy), 32'd1);
      req_val = 1'b0;
   endtask

   // Scoreboard and counter model, sampled mid-cycle
   always @(negedge clk) begin
      if (!reset) begin
         check("num_enc", 32'(num_enc), 32'(exp_enc));
         check("num_err", 32'(num_err), 32'(exp_err));
         if (resp_val && resp_rdy) begin
            if (exp_q.size() == 0) begin
               check("spurious_resp", 32'(resp_val), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.rt) begin
                  check("rt_imm", imm_decode(mon_e.typ, resp_inst), mon_e.imm);
               end else begin
                  check("resp_inst", resp_inst, mon_e.inst);
               end
               check("resp_err", 32'(resp_err), 32'(mon_e.err));
               if (exp_enc != CMAX) exp_enc = exp_enc + 1'b1;
               if (mon_e.err && (exp_err != CMAX)) exp_err = exp_err + 1'b1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        go;
      logic [31:0] held;
      logic [31:0] r;
      logic [31:0] imm;
      logic [2:0]  t;
      int          acc;

      reset = 1'b1; req_val = 1'b0; resp_rdy = 1'b1;
      req_imm_type = 3'd0; req_opcode = 7'd0; req_funct3 = 3'd0; req_funct7 = 7'd0;
      req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd0;
      exp_enc = '0; exp_err = '0;
      #12;
      check("rst_val", 32'(resp_val), 32'd0);
      check("rst_inst", resp_inst, 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      check("rst_enc", 32'(num_enc), 32'd0);
      check("rst_nerr", 32'(num_err), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rdy_after_rst", 32'(req_rdy), 32'd1);
      tick();

      // Latency of a single I-type request
      push(IMM_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0, 1'b0);
      @(negedge clk);
      check("lat_x", 32'(resp_val), 32'd0);
      @(negedge clk);
      check("lat_w", 32'(resp_val), 32'd1);
      check("lat_inst", resp_inst, 32'hFFF1_0093);
      tick();

      // Directed encodings, legal and out of range, streamed back to back
      push(IMM_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_8463, 1'b0, 1'b0);
      push(IMM_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd9,          32'h0020_8463, 1'b1, 1'b0);
      push(IMM_U, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0, 1'b0);
      push(IMM_U, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001,  32'h1234_52B7, 1'b1, 1'b0);
      push(3'd7,  7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0,          32'd0,         1'b1, 1'b0);
      push(3'd6,  7'h33, 3'd1, 7'd1, 5'd1, 5'd2, 5'd3, 32'd4,          32'd0,         1'b1, 1'b0);
      push(IMM_S, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC,  32'hFE31_2E23, 1'b0, 1'b0);
      push(IMM_J, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800,  32'h0010_00EF, 1'b0, 1'b0);
      push(IMM_J, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3,          32'h0020_00EF, 1'b1, 1'b0);
      push(IMM_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF,  32'h0020_81B3, 1'b0, 1'b0);
      push(IMM_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_F800,  32'h8001_0093, 1'b0, 1'b0);
      push(IMM_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0800,  32'h8001_0093, 1'b1, 1'b0);
      repeat (4) tick();
      check("drain_directed", 32'(exp_q.size()), 32'd0);

      // Backpressure: four requests against a stalled consumer, then release
      acc = 0;
      resp_rdy = 1'b0;
      req_imm_type = IMM_I; req_opcode = 7'h13; req_funct3 = 3'd0; req_funct7 = 7'd0;
      req_rs1 = 5'd2; req_rs2 = 5'd0; req_rd = 5'd1; req_imm = 32'd0;
      req_val = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         go = req_val & req_rdy;
         if (c == 2) held = resp_inst;
         if (c == 5) begin
            check("bp_acc", 32'(acc), 32'd2);
            check("bp_rdy", 32'(req_rdy), 32'd0);
            check("bp_val", 32'(resp_val), 32'd1);
            check("bp_hold", resp_inst, held);
         end
         if (c >= 6 && c <= 9) check("bp_tput", 32'(resp_val), 32'd1);
         @(posedge clk);
         #1;
         if (go) begin
            exp_q.push_back('{inst: (32'(acc) << 20) | (32'd2 << 15) | (32'(acc + 1) << 7) | 32'h13,
                              err: 1'b0, rt: 1'b0, typ: IMM_I, imm: 32'(acc)});
            acc++;
            if (acc < 4) begin
               req_rd = 5'(acc + 1);
               req_imm = 32'(acc);
            end else begin
               req_val = 1'b0;
            end
         end
         if (c == 5) resp_rdy = 1'b1;
      end
      check("bp_total", 32'(acc), 32'd4);
      check("drain_bp", 32'(exp_q.size()), 32'd0);

      // Reset with both stages full
      resp_rdy = 1'b0;
      push(IMM_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0, 1'b0);
      push(IMM_R, 7'h33, 3'd0, 7'd0, 5'd4, 5'd1, 5'd2, 32'd0, 32'h0020_8233, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      exp_q.delete();
      exp_enc = '0;
      exp_err = '0;
      #1;
      check("mid_rst_val", 32'(resp_val), 32'd0);
      check("mid_rst_inst", resp_inst, 32'd0);
      check("mid_rst_enc", 32'(num_enc), 32'd0);
      check("mid_rst_nerr", 32'(num_err), 32'd0);
      tick();
      reset = 1'b0;
      resp_rdy = 1'b1;
      @(negedge clk);
      check("rdy_after_rst2", 32'(req_rdy), 32'd1);
      for (int c = 0; c < 5; c++) begin
         check("no_stale", 32'(resp_val), 32'd0);
         @(negedge clk);
      end
      tick();

      // Round trip of random legal immediates
      for (int n = 0; n < 200; n++) begin
         r = $urandom;
         case ($urandom_range(0, 3))
            0:       begin t = IMM_I; imm = {{20{r[11]}}, r[11:0]}; end
            1:       begin t = IMM_S; imm = {{20{r[11]}}, r[11:0]}; end
            2:       begin t = IMM_B; imm = {{19{r[12]}}, r[12:1], 1'b0}; end
            default: begin t = IMM_J; imm = {{11{r[20]}}, r[20:1], 1'b0}; end
         endcase
         push(t, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), imm, 32'd0, 1'b0, 1'b1);
      end

      // Illegal types drive both counters into saturation
      for (int n = 0; n < 270; n++) begin
         push(3'(6 + (n % 2)), 7'($urandom), 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, $urandom,
              32'd0, 1'b1, 1'b0);
      end
      repeat (4) tick();
      check("drain_final", 32'(exp_q.size()), 32'd0);
      check("sat_enc", 32'(num_enc), 32'(CMAX));
      check("sat_err", 32'(num_err), 32'(CMAX));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
